// File: rtl/pipeline_run_ctrl.sv
// Run/step/pause/clear sequencer for the 5-stage pipeline, driven by the debug unit.
// A fetched HALT drains the in-flight instructions through WB, then parks in HALTED.
module pipeline_run_ctrl #(
  parameter int NBITS        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_halt_fetched,
  output logic             o_pipe_en,
  output logic             o_pc_en,
  output logic             o_pipe_flush,
  output logic [2:0]       o_state,
  output logic [NBITS-1:0] o_cycle_cnt,
  output logic             o_done
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);

  localparam logic [1:0] CMD_STOP  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4,
    CLEAR  = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic [DW-1:0]    drain_reg, drain_next;
  logic [NBITS-1:0] cnt_reg;
  logic             done_reg;
  logic             cmd_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      drain_reg <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      drain_reg <= drain_next;
      done_reg  <= (state_next == HALTED) && (state_reg != HALTED);
      if (state_reg == CLEAR)
        cnt_reg <= '0;
      else if (o_pipe_en && (cnt_reg != {NBITS{1'b1}}))
        cnt_reg <= cnt_reg + NBITS'(1);
    end
  end

  always_comb begin
    state_next   = state_reg;
    drain_next   = drain_reg;
    o_pipe_en    = 1'b0;
    o_pc_en      = 1'b0;
    o_pipe_flush = 1'b0;
    o_cmd_ready  = 1'b0;

    case (state_reg)
      IDLE, HALTED: o_cmd_ready = 1'b1;
      RUN:   begin o_cmd_ready = 1'b1; o_pipe_en = 1'b1; o_pc_en = 1'b1; end
      STEP:  begin o_pipe_en = 1'b1; o_pc_en = 1'b1; end
      DRAIN: o_pipe_en = 1'b1;
      CLEAR: o_pipe_flush = 1'b1;
      default: ;
    endcase

    cmd_acc = i_cmd_valid && o_cmd_ready;

    case (state_reg)
      IDLE: begin
        if (cmd_acc) begin
          case (i_cmd)
            CMD_RUN:   state_next = RUN;
            CMD_STEP:  state_next = STEP;
            CMD_CLEAR: state_next = CLEAR;
            default:   state_next = IDLE;
          endcase
        end
      end
      RUN: begin
        // A fetched HALT outranks a simultaneous STOP so the program still retires cleanly
        if (i_halt_fetched) begin
          state_next = DRAIN;
          drain_next = DRAIN_LOAD;
        end else if (cmd_acc && (i_cmd == CMD_STOP)) begin
          state_next = IDLE;
        end
      end
      STEP: begin
        if (i_halt_fetched) begin
          state_next = DRAIN;
          drain_next = DRAIN_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        drain_next = drain_reg - DRAIN_ONE;
        if (drain_reg == DRAIN_ONE)
          state_next = HALTED;
      end
      HALTED: begin
        if (cmd_acc && (i_cmd == CMD_CLEAR))
          state_next = CLEAR;
      end
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign o_state     = state_reg;
  assign o_cycle_cnt = cnt_reg;
  assign o_done      = done_reg;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Randomized plus directed bench for pipeline_run_ctrl, checked every cycle against
// a behavioural model; a second 4-bit-counter instance covers counter saturation.
module tb_pipeline_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        halt = 1'b0;

  logic        ready, pipe_en, pc_en, flush, done;
  logic [2:0]  state;
  logic [31:0] cnt;

  logic        ready4, pipe_en4, pc_en4, flush4, done4;
  logic [2:0]  state4;
  logic [3:0]  cnt4;

  int errors = 0;
  int checks = 0;

  // model state (spec codes: IDLE=0 RUN=1 STEP=2 DRAIN=3 HALTED=4 CLEAR=5)
  int              m_state = 0;
  int              m_left = 0;
  longint unsigned m_cnt = 0;
  int              m_cnt4 = 0;
  bit              m_done = 0;

  always #5 clk = ~clk;

  pipeline_run_ctrl #(.NBITS(32), .DRAIN_CYCLES(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(ready), .i_halt_fetched(halt), .o_pipe_en(pipe_en),
    .o_pc_en(pc_en), .o_pipe_flush(flush), .o_state(state),
    .o_cycle_cnt(cnt), .o_done(done)
  );

  pipeline_run_ctrl #(.NBITS(4), .DRAIN_CYCLES(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .o_cmd_ready(ready4), .i_halt_fetched(halt), .o_pipe_en(pipe_en4),
    .o_pc_en(pc_en4), .o_pipe_flush(flush4), .o_state(state4),
    .o_cycle_cnt(cnt4), .o_done(done4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit accepts(int s);
    return (s == 0) || (s == 1) || (s == 4);
  endfunction

  // One clock edge of the specified behaviour.
  task automatic model_edge(bit r, bit v, bit [1:0] c, bit h);
    int  ns;
    bit  take;
    if (r) begin
      m_state = 0; m_left = 0; m_cnt = 0; m_cnt4 = 0; m_done = 0;
      return;
    end
    take = v && accepts(m_state);
    if (m_state inside {1, 2, 3}) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
    end
    if (m_state == 5) begin
      m_cnt = 0; m_cnt4 = 0;
    end
    ns = m_state;
    if (m_state == 0 && take && c != 0) ns = (c == 1) ? 1 : (c == 2) ? 2 : 5;
    else if ((m_state == 1 || m_state == 2) && h) begin ns = 3; m_left = 4; end
    else if (m_state == 1 && take && c == 0) ns = 0;
    else if (m_state == 2) ns = 0;
    else if (m_state == 3) begin
      m_left = m_left - 1;
      if (m_left == 0) ns = 4;
    end
    else if (m_state == 4 && take && c == 3) ns = 5;
    else if (m_state == 5) ns = 0;
    m_done = (ns == 4) && (m_state != 4);
    m_state = ns;
  endtask

  task automatic check_all();
    chk("state",   state,   m_state[2:0]);
    chk("pipe_en", pipe_en, m_state inside {1, 2, 3});
    chk("pc_en",   pc_en,   m_state inside {1, 2});
    chk("flush",   flush,   m_state == 5);
    chk("ready",   ready,   accepts(m_state));
    chk("cnt",     cnt,     m_cnt);
    chk("done",    done,    m_done);
    chk("cnt4",    cnt4,    m_cnt4[3:0]);
    chk("state4",  state4,  m_state[2:0]);
  endtask

  // Drive inputs for one cycle (called at a negedge), clock it, check at the next negedge.
  task automatic cyc(bit r, bit v, bit [1:0] c, bit h);
    rst = r; cmd_valid = v; cmd = c; halt = h;
    @(posedge clk);
    model_edge(r, v, c, h);
    @(negedge clk);
    check_all();
    $display("cyc t=%0t rst=%0b v=%0b cmd=%0d halt=%0b -> state=%0d pe=%0b cnt=%0d done=%0b",
             $time, r, v, c, h, state, pipe_en, cnt, done);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 0);
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 2'd0, 0);
    cyc(1, 1, 2'd1, 1);  // reset held overrides commands
    chk("rst_ready", ready, 1);

    // RUN for 10 cycles then STOP
    cyc(0, 1, 2'd1, 0);
    idle(9);
    cyc(0, 1, 2'd0, 0);
    chk("s1_state", state, 0);
    chk("s1_cnt", cnt, 10);

    // CLEAR, then RUN with HALT in the 5th RUN cycle
    cyc(0, 1, 2'd3, 0);
    idle(1);
    cyc(0, 1, 2'd1, 0);
    idle(4);
    cyc(0, 0, 2'd0, 1);
    chk("s2_pc_off", pc_en, 0);
    idle(4);
    chk("s2_state", state, 4);
    chk("s2_done", done, 1);
    chk("s2_cnt", cnt, 9);
    idle(1);
    chk("s2_done_once", done, 0);

    // CLEAR, then three single steps
    cyc(0, 1, 2'd3, 0);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 2'd2, 0);
      chk("s3_step_ready", ready, 0);
      idle(1);
    end
    chk("s3_cnt", cnt, 3);

    // CLEAR, STEP onto a HALT, drain, ignore RUN, CLEAR
    cyc(0, 1, 2'd3, 0);
    idle(1);
    cyc(0, 1, 2'd2, 0);
    cyc(0, 0, 2'd0, 1);
    idle(3);
    cyc(0, 0, 2'd0, 0);
    chk("s4_state", state, 4);
    chk("s4_cnt", cnt, 5);
    cyc(0, 1, 2'd1, 0);
    chk("s4_run_ignored", state, 4);
    cyc(0, 1, 2'd3, 0);
    chk("s4_flush", flush, 1);
    idle(1);
    chk("s4_flush_off", flush, 0);
    chk("s4_cnt0", cnt, 0);

    // STOP and HALT together while running: HALT wins
    cyc(0, 1, 2'd1, 0);
    cyc(0, 1, 2'd0, 1);
    chk("s5_drain", state, 3);

    // Reset during the 2nd DRAIN cycle
    idle(1);
    cyc(1, 0, 2'd0, 0);
    chk("s6_state", state, 0);
    chk("s6_cnt", cnt, 0);
    chk("s6_pe", pipe_en, 0);
    idle(6);
    chk("s6_no_done", done, 0);

    // 4-bit counter saturates
    cyc(0, 1, 2'd1, 0);
    idle(19);
    chk("s7_sat", cnt4, 15);
    cyc(0, 1, 2'd0, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit          r = ($urandom_range(0, 99) == 0);
      bit          v = ($urandom_range(0, 2) == 0);
      logic [1:0]  c = 2'($urandom_range(0, 3));
      bit          h = ($urandom_range(0, 9) == 0);
      cyc(r, v, c, h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
